// File: rtl/ewb_multi.sv
// Multi-entry eviction write buffer between the data cache and the memory adaptor.
// Evictions are acked at once and queued in a FIFO, drained when the cache is idle, and read hits are served from the buffer.
module ewb_multi #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LINE_W-1:0]        cache_wdata,
    input  logic [ADDR_W-1:0]        cache_address,
    input  logic                     cache_read,
    input  logic                     cache_write,
    output logic                     cache_resp,
    output logic [LINE_W-1:0]        cache_rdata,
    input  logic [LINE_W-1:0]        pmem_rdata,
    input  logic                     pmem_resp,
    output logic [LINE_W-1:0]        pmem_wdata,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned OFS   = $clog2(LINE_W / 8);
    localparam int unsigned TAG_W = ADDR_W - OFS;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_ACK = 3'd1;
    localparam logic [2:0] RD_HIT = 3'd2;
    localparam logic [2:0] RD_MEM = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [PTR_W-1:0]  hit_idx_q;
    logic [CNT_W-1:0]  count_q;

    logic [TAG_W-1:0]  req_tag;
    logic              match;
    logic [PTR_W-1:0]  match_idx;
    logic              push;
    logic              coalesce;
    logic              pop;
    logic              latch_hit;

    assign req_tag   = cache_address[ADDR_W-1:OFS];
    assign occupancy = count_q;

    // Line-address match against all valid entries; coalescing keeps it one-hot.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                match     = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        push         = 1'b0;
        coalesce     = 1'b0;
        pop          = 1'b0;
        latch_hit    = 1'b0;
        cache_resp   = 1'b0;
        cache_rdata  = pmem_rdata;
        pmem_wdata   = data_q[head_q];
        pmem_address = cache_address;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cache_read) begin
                    if (match) begin
                        latch_hit = 1'b1;
                        state_d   = RD_HIT;
                    end else begin
                        state_d = RD_MEM;
                    end
                end else if (cache_write) begin
                    if (match) begin
                        coalesce = 1'b1;
                        state_d  = WR_ACK;
                    end else if (count_q < CNT_W'(DEPTH)) begin
                        push    = 1'b1;
                        state_d = WR_ACK;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (count_q != '0) begin
                    state_d = DRAIN;
                end
            end
            WR_ACK: begin
                cache_resp = 1'b1;
                state_d    = IDLE;
            end
            RD_HIT: begin
                cache_resp  = 1'b1;
                cache_rdata = data_q[hit_idx_q];
                state_d     = IDLE;
            end
            RD_MEM: begin
                pmem_read  = 1'b1;
                cache_resp = pmem_resp;
                if (pmem_resp) state_d = IDLE;
            end
            DRAIN: begin
                // Head stays valid until its write completes so a read cannot slip past it.
                pmem_write   = 1'b1;
                pmem_address = {tag_q[head_q], {OFS{1'b0}}};
                if (pmem_resp) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            hit_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_hit) hit_idx_q <= match_idx;
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= PTR_W'(tail_q + PTR_W'(1));
                count_q         <= CNT_W'(count_q + CNT_W'(1));
            end else if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= PTR_W'(head_q + PTR_W'(1));
                count_q         <= CNT_W'(count_q - CNT_W'(1));
            end
        end
    end

    // Payload storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail_q]  <= req_tag;
            data_q[tail_q] <= cache_wdata;
        end else if (coalesce) begin
            data_q[match_idx] <= cache_wdata;
        end
    end

endmodule

// File: tb/tb_ewb_multi.sv
// Self-checking bench for ewb_multi: scoreboard queues for read data and drained lines,
// plus per-scenario latency/occupancy checks.
module tb_ewb_multi;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [LINE_W-1:0] cache_wdata;
    logic [ADDR_W-1:0] cache_address;
    logic              cache_read;
    logic              cache_write;
    logic              cache_resp;
    logic [LINE_W-1:0] cache_rdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_wdata;
    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [CNT_W-1:0]  occupancy;

    int n_tests = 0;
    int n_fail  = 0;
    bit pread_seen = 1'b0;
    bit prev_resp  = 1'b0;

    logic [LINE_W-1:0] rd_q[$];
    logic [ADDR_W-1:0] dq_addr[$];
    logic [LINE_W-1:0] dq_data[$];

    ewb_multi #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cache_wdata(cache_wdata), .cache_address(cache_address),
        .cache_read(cache_read), .cache_write(cache_write),
        .cache_resp(cache_resp), .cache_rdata(cache_rdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .pmem_wdata(pmem_wdata), .pmem_address(pmem_address),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: pops expected read data and drained lines as the DUT completes them.
    always @(negedge clk) begin
        if (rst) begin
            if (pmem_read) pread_seen = 1'b1;
            if (pmem_read && pmem_write) begin
                n_tests++; n_fail++;
                $display("FAIL pmem_excl: read and write both high at %0t", $time);
            end
            if (cache_resp && prev_resp) begin
                n_tests++; n_fail++;
                $display("FAIL resp_twice: cache_resp high two cycles at %0t", $time);
            end
            prev_resp = cache_resp;
            if (cache_resp && cache_read) begin
                n_tests++;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected: rdata %h with empty queue", cache_rdata);
                end else begin
                    logic [LINE_W-1:0] e;
                    e = rd_q.pop_front();
                    if (cache_rdata !== e) begin
                        n_fail++;
                        $display("FAIL rd_data: got %h exp %h", cache_rdata, e);
                    end
                end
            end
            if (pmem_write && pmem_resp) begin
                n_tests++;
                if (dq_addr.size() == 0) begin
                    n_fail++;
                    $display("FAIL drain_unexpected: addr %h", pmem_address);
                end else begin
                    logic [ADDR_W-1:0] ea;
                    logic [LINE_W-1:0] ed;
                    ea = dq_addr.pop_front();
                    ed = dq_data.pop_front();
                    if (pmem_address !== ea || pmem_wdata !== ed) begin
                        n_fail++;
                        $display("FAIL drain: got %h/%h exp %h/%h", pmem_address, pmem_wdata, ea, ed);
                    end
                end
            end
        end else begin
            prev_resp = 1'b0;
        end
    end

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            @(negedge clk);
            if (cache_resp) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_pwrite(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            @(negedge clk);
            if (pmem_write) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic mem_pulse(input logic [LINE_W-1:0] rdata, output logic resp_seen);
        tick();
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        @(negedge clk);
        resp_seen = cache_resp;
        tick();
        pmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cache_wdata = '0; cache_address = '0; cache_read = 1'b0; cache_write = 1'b0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({cache_resp, pmem_read, pmem_write} !== 3'b000 || occupancy !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL reset_outputs: resp/rd/wr=%b%b%b occ=%0d exp 000 occ=0",
                     cache_resp, pmem_read, pmem_write, occupancy);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_write_drain();
        int lat;
        logic rs;
        logic [LINE_W-1:0] a;
        a = rnd_line();
        tick();
        cache_address = 32'h1000; cache_wdata = a; cache_write = 1'b1;
        dq_addr.push_back(32'h1000); dq_data.push_back(a);
        wait_resp(5, lat);
        n_tests++;
        if (lat != 1) begin n_fail++; $display("FAIL wr_ack_lat: got %0d exp 1", lat); end
        n_tests++;
        if (occupancy !== CNT_W'(1)) begin n_fail++; $display("FAIL wr_occ: got %0d exp 1", occupancy); end
        tick();
        cache_write = 1'b0;
        wait_pwrite(5, lat);
        n_tests++;
        if (lat < 0 || pmem_address !== 32'h1000 || pmem_wdata !== a) begin
            n_fail++;
            $display("FAIL drain_start: lat %0d addr %h exp 1000", lat, pmem_address);
        end
        mem_pulse('0, rs);
        @(negedge clk);
        n_tests++;
        if (occupancy !== CNT_W'(0)) begin n_fail++; $display("FAIL drain_occ: got %0d exp 0", occupancy); end
    endtask

    task automatic test_coalesce();
        int lat;
        logic rs;
        logic [LINE_W-1:0] a, b;
        a = rnd_line();
        b = rnd_line();
        tick();
        cache_address = 32'h1000; cache_wdata = a; cache_write = 1'b1;
        wait_resp(5, lat);
        tick();
        cache_wdata = b;
        dq_addr.push_back(32'h1000); dq_data.push_back(b);
        wait_resp(5, lat);
        n_tests++;
        if (lat != 1 || occupancy !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL coalesce_ack: lat %0d occ %0d exp lat 1 occ 1", lat, occupancy);
        end
        tick();
        cache_write = 1'b0;
        wait_pwrite(5, lat);
        repeat (3) tick();
        @(negedge clk);
        n_tests++;
        if (pmem_write !== 1'b1 || occupancy !== CNT_W'(1) || pmem_wdata !== b) begin
            n_fail++;
            $display("FAIL coalesce_hold: wr %b occ %0d wdata %h exp 1/1/%h", pmem_write, occupancy, pmem_wdata, b);
        end
        mem_pulse('0, rs);
        @(negedge clk);
        n_tests++;
        if (occupancy !== CNT_W'(0)) begin n_fail++; $display("FAIL coalesce_occ: got %0d exp 0", occupancy); end
    endtask

    task automatic test_read_hit();
        int lat;
        logic rs;
        logic [LINE_W-1:0] c;
        c = rnd_line();
        tick();
        cache_address = 32'h2000; cache_wdata = c; cache_write = 1'b1;
        wait_resp(5, lat);
        tick();
        cache_write = 1'b0; cache_read = 1'b1; cache_address = 32'h2004;
        pread_seen = 1'b0;
        rd_q.push_back(c);
        wait_resp(5, lat);
        n_tests++;
        if (lat != 1) begin n_fail++; $display("FAIL rdhit_lat: got %0d exp 1", lat); end
        tick();
        cache_read = 1'b0;
        n_tests++;
        if (pread_seen !== 1'b0) begin n_fail++; $display("FAIL rdhit_pmem: pmem_read seen %b exp 0", pread_seen); end
        dq_addr.push_back(32'h2000); dq_data.push_back(c);
        wait_pwrite(5, lat);
        mem_pulse('0, rs);
    endtask

    task automatic test_full();
        int lat;
        int bad;
        logic rs;
        logic [LINE_W-1:0] d;
        bad = 0;
        tick();
        cache_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = rnd_line();
            cache_address = ADDR_W'(32'h100 * (i + 1)); cache_wdata = d;
            dq_addr.push_back(cache_address); dq_data.push_back(d);
            wait_resp(5, lat);
            if (lat != 1) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0 || occupancy !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL fill: bad acks %0d occ %0d exp 0 and 4", bad, occupancy);
        end
        d = rnd_line();
        cache_address = 32'h500; cache_wdata = d;
        dq_addr.push_back(32'h500); dq_data.push_back(d);
        wait_resp(4, lat);
        n_tests++;
        if (lat != -1) begin n_fail++; $display("FAIL full_stall: resp after %0d exp none", lat); end
        n_tests++;
        if (pmem_write !== 1'b1 || pmem_address !== 32'h100) begin
            n_fail++;
            $display("FAIL full_drain: wr %b addr %h exp 1/100", pmem_write, pmem_address);
        end
        mem_pulse('0, rs);
        wait_resp(3, lat);
        n_tests++;
        if (lat != 1 || occupancy !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL full_ack: lat %0d occ %0d exp 1 and 4", lat, occupancy);
        end
        tick();
        cache_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_pwrite(5, lat);
            mem_pulse('0, rs);
        end
        @(negedge clk);
        n_tests++;
        if (occupancy !== CNT_W'(0)) begin n_fail++; $display("FAIL full_empty: occ %0d exp 0", occupancy); end
    endtask

    task automatic test_read_miss();
        int lat;
        logic rs;
        logic [LINE_W-1:0] d, r;
        d = rnd_line();
        r = rnd_line();
        tick();
        cache_address = 32'h3000; cache_wdata = d; cache_write = 1'b1;
        wait_resp(5, lat);
        tick();
        cache_write = 1'b0; cache_read = 1'b1; cache_address = 32'h8000;
        tick();
        @(negedge clk);
        n_tests++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h8000) begin
            n_fail++;
            $display("FAIL miss_pread: rd %b wr %b addr %h exp 1/0/8000", pmem_read, pmem_write, pmem_address);
        end
        rd_q.push_back(r);
        mem_pulse(r, rs);
        cache_read = 1'b0;
        n_tests++;
        if (rs !== 1'b1) begin n_fail++; $display("FAIL miss_resp: resp %b with pmem_resp exp 1", rs); end
        dq_addr.push_back(32'h3000); dq_data.push_back(d);
        wait_pwrite(5, lat);
        mem_pulse('0, rs);
    endtask

    task automatic test_reset_mid_drain();
        int lat;
        logic rs;
        logic [LINE_W-1:0] g, h;
        g = rnd_line();
        h = rnd_line();
        tick();
        cache_address = 32'h4000; cache_wdata = g; cache_write = 1'b1;
        wait_resp(5, lat);
        tick();
        cache_write = 1'b0;
        wait_pwrite(5, lat);
        n_tests++;
        if (lat < 0) begin n_fail++; $display("FAIL rst_pre_drain: no drain seen, lat %0d", lat); end
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (pmem_write !== 1'b0 || occupancy !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL rst_async: wr %b occ %0d exp 0/0", pmem_write, occupancy);
        end
        tick();
        rst = 1'b1;
        tick();
        cache_read = 1'b1; cache_address = 32'h4000;
        tick();
        @(negedge clk);
        n_tests++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h4000) begin
            n_fail++;
            $display("FAIL rst_read_mem: rd %b addr %h exp 1/4000", pmem_read, pmem_address);
        end
        rd_q.push_back(h);
        mem_pulse(h, rs);
        cache_read = 1'b0;
        n_tests++;
        if (rs !== 1'b1) begin n_fail++; $display("FAIL rst_read_resp: resp %b exp 1", rs); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_drain();
        test_coalesce();
        test_read_hit();
        test_full();
        test_read_miss();
        test_reset_mid_drain();
        repeat (3) tick();
        n_tests++;
        if (rd_q.size() != 0 || dq_addr.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: rd %0d drain %0d exp 0/0", rd_q.size(), dq_addr.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
